// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit interval timer on the cpu bus.
// The timer occupies a 4-byte window at BASE_ADDR and contains four registers:
//   +0 CNT_L  read: live counter[7:0], which also snapshots counter[15:8]
//             write: latch_l
//   +1 CNT_H  read: snapshot of the high byte
//             write: latch_h, load counter, clear IF
//   +2 CTRL   bit0 EN, bit1 CONT (auto-reload), bit2 IE
//   +3 STAT   read: {running, IF}
//             write: a 1 in bit0 clears IF
// Reads are combinational so the cpu can sample data_read on the same edge.
module bus_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int          PRESCALE  = 4,
    parameter int          PRE_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OFF_CNT_L = 2'd0;
    localparam logic [1:0] OFF_CNT_H = 2'd1;
    localparam logic [1:0] OFF_CTRL  = 2'd2;
    localparam logic [1:0] OFF_STAT  = 2'd3;

    // Last prescaler value before a tick.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // State registers and their next-state values.
    state_t             state_q,    state_d;
    logic [15:0]        counter_q,  counter_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [7:0]         latch_l_q,  latch_l_d;
    logic [7:0]         latch_h_q,  latch_h_d;
    logic [7:0]         snap_h_q,   snap_h_d;
    logic [2:0]         ctrl_q,     ctrl_d;
    logic               if_q,       if_d;

    // Bus decode strobes.
    logic [1:0] offset;
    logic       rd_sel;
    logic       wr_sel;
    logic       rd_cnt_l;
    logic       wr_cnt_l;
    logic       wr_cnt_h;
    logic       wr_ctrl;
    logic       wr_stat;

    // Timer events.
    logic       running;
    logic       tick;
    logic       expire;
    logic       ctrl_en;
    logic       ctrl_cont;
    logic       ctrl_ie;

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_cont = ctrl_q[1];
    assign ctrl_ie   = ctrl_q[2];

    // The window is 4-byte aligned, so only address bits [15:2] take part
    // in the match.
    assign selected = (address[15:2] == BASE_ADDR[15:2]);
    assign offset   = address[1:0];
    assign rd_sel   = selected &  read_write;
    assign wr_sel   = selected & ~read_write;

    assign rd_cnt_l = rd_sel && (offset == OFF_CNT_L);
    assign wr_cnt_l = wr_sel && (offset == OFF_CNT_L);
    assign wr_cnt_h = wr_sel && (offset == OFF_CNT_H);
    assign wr_ctrl  = wr_sel && (offset == OFF_CTRL);
    assign wr_stat  = wr_sel && (offset == OFF_STAT);

    assign running = (state_q == ST_RUN);
    assign tick    = running && (prescale_q == PRE_LAST);
    assign expire  = tick && (counter_q == 16'd0);
    assign irq     = if_q & ctrl_ie;

    // Combinational read mux.
    // An unselected slave drives zero so the bus can OR all slaves together.
    always_comb begin
        data_out = 8'h00;
        if (rd_sel) begin
            case (offset)
                OFF_CNT_L: data_out = counter_q[7:0];
                OFF_CNT_H: data_out = snap_h_q;
                OFF_CTRL:  data_out = {5'b00000, ctrl_q};
                OFF_STAT:  data_out = {6'b000000, running, if_q};
                default:   data_out = 8'h00;
            endcase
        end
    end

    // Next-state logic for the bus-visible registers: latches, snapshot and CTRL.
    always_comb begin
        latch_l_d = latch_l_q;
        latch_h_d = latch_h_q;
        snap_h_d  = snap_h_q;
        ctrl_d    = ctrl_q;
        if (wr_cnt_l) begin
            latch_l_d = data_write;
        end
        if (wr_cnt_h) begin
            latch_h_d = data_write;
        end
        if (rd_cnt_l) begin
            snap_h_d = counter_q[15:8];
        end
        if (wr_ctrl) begin
            ctrl_d = data_write[2:0];
        end
    end

    // Timer FSM next state together with the counter, prescaler and IF.
    // A load overrides everything else in the same cycle.
    // Everything else in this block reads the CTRL value from before any
    // write in the same cycle.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        prescale_d = prescale_q;
        if_d       = if_q;

        if (wr_cnt_h) begin
            counter_d  = {data_write, latch_l_q};
            prescale_d = '0;
            if_d       = 1'b0;
            state_d    = ctrl_en ? ST_RUN : ST_IDLE;
        end else begin
            // The clear is applied first so that an expiry in the same
            // cycle overrides it.
            if (wr_stat && data_write[0]) begin
                if_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (wr_ctrl && data_write[0]) begin
                        state_d = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (tick) begin
                        prescale_d = '0;
                        if (counter_q != 16'd0) begin
                            counter_d = counter_q - 16'd1;
                        end else begin
                            if_d = 1'b1;
                            if (ctrl_cont) begin
                                counter_d = {latch_h_q, latch_l_q};
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        prescale_d = prescale_q + 1'b1;
                    end

                    // Pausing keeps the count and the prescaler phase.
                    // A one-shot expiry on the same edge still goes to DONE.
                    if (wr_ctrl && !data_write[0] && !(expire && !ctrl_cont)) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_DONE: begin
                    // Only a load leaves DONE.
                    state_d = ST_DONE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            counter_q  <= 16'd0;
            prescale_q <= '0;
            latch_l_q  <= 8'h00;
            latch_h_q  <= 8'h00;
            snap_h_q   <= 8'h00;
            ctrl_q     <= 3'b000;
            if_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            prescale_q <= prescale_d;
            latch_l_q  <= latch_l_d;
            latch_h_q  <= latch_h_d;
            snap_h_q   <= snap_h_d;
            ctrl_q     <= ctrl_d;
            if_q       <= if_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed bench for bus_timer with BASE_ADDR=D000 and PRESCALE=4.
// Bus cycles are driven from the falling edge and take effect on the next rising edge.
// Outputs are sampled away from the rising edge.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        read_write = 1'b1;
    logic [7:0]  data_write = 8'h00;
    logic [7:0]  data_out;
    logic        selected;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    bus_timer dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_out   (data_out),
        .selected   (selected),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        read_write = 1'b0;
        data_write = d;
        @(posedge clk);
        #1;
        address    = 16'h0000;
        read_write = 1'b1;
        data_write = 8'h00;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        address    = a;
        read_write = 1'b1;
        #1;
        check(tag, {8'h00, data_out}, {8'h00, exp});
        @(posedge clk);
        #1;
        address = 16'h0000;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {15'b0, irq}, {15'b0, exp});
    endtask

    initial begin
        // Check the state right after power-on reset.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_irq("por_irq", 1'b0);
        rst = 1'b0;
        read_check("por_stat", 16'hD003, 8'h00);

        // Run in continuous mode from count 0 and expire every 4 edges.
        // Then reset in the middle of the count.
        bus_write(16'hD002, 8'h07);
        wait_edges(6);
        check_irq("cont0_irq", 1'b1);
        read_check("cont0_stat", 16'hD003, 8'h03);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_irq("rst_irq", 1'b0);
        rst = 1'b0;
        read_check("rst_cnt_l", 16'hD000, 8'h00);
        read_check("rst_cnt_h", 16'hD001, 8'h00);
        read_check("rst_ctrl",  16'hD002, 8'h00);
        read_check("rst_stat",  16'hD003, 8'h00);

        // One-shot: load 3, so IF is expected 16 edges after the CNT_H write.
        bus_write(16'hD002, 8'h05);
        bus_write(16'hD000, 8'h03);
        bus_write(16'hD001, 8'h00);
        wait_edges(15);
        check_irq("os_before", 1'b0);
        wait_edges(1);
        check_irq("os_expire", 1'b1);
        read_check("os_stat",  16'hD003, 8'h01);
        read_check("os_cnt_l", 16'hD000, 8'h00);
        read_check("os_cnt_h", 16'hD001, 8'h00);
        wait_edges(40);
        check_irq("os_hold_irq", 1'b1);
        read_check("os_hold_stat", 16'hD003, 8'h01);
        read_check("os_hold_cnt",  16'hD000, 8'h00);

        // Continuous: load 2, so the period is 12 edges.
        // Clearing IF does not disturb the period.
        bus_write(16'hD002, 8'h07);
        bus_write(16'hD000, 8'h02);
        bus_write(16'hD001, 8'h00);
        wait_edges(11);
        check_irq("ct_before", 1'b0);
        wait_edges(1);
        check_irq("ct_first", 1'b1);
        bus_write(16'hD003, 8'h01);
        check_irq("ct_cleared", 1'b0);
        wait_edges(10);
        check_irq("ct_before2", 1'b0);
        wait_edges(1);
        check_irq("ct_second", 1'b1);
        bus_write(16'hD002, 8'h00);

        // Coherent read: the CNT_H read returns the high byte captured by the
        // last CNT_L read.
        bus_write(16'hD002, 8'h01);
        bus_write(16'hD000, 8'h00);
        bus_write(16'hD001, 8'h01);
        read_check("coh_lo_0100", 16'hD000, 8'h00);
        wait_edges(8);
        read_check("coh_snap_01", 16'hD001, 8'h01);
        read_check("coh_lo_00fe", 16'hD000, 8'hFE);
        wait_edges(8);
        read_check("coh_snap_00", 16'hD001, 8'h00);

        // Pause on a non-tick edge, hold for 20 cycles, then resume.
        // The prescaler phase is kept, so the next tick arrives 3 edges after
        // the resume write.
        bus_write(16'hD002, 8'h00);
        wait_edges(20);
        read_check("pause_frozen", 16'hD000, 8'hFB);
        read_check("pause_stat",   16'hD003, 8'h00);
        bus_write(16'hD002, 8'h01);
        wait_edges(2);
        read_check("resume_pre",  16'hD000, 8'hFB);
        read_check("resume_tick", 16'hD000, 8'hFA);

        // A clear-write on the expiry edge leaves IF set.
        bus_write(16'hD002, 8'h05);
        bus_write(16'hD000, 8'h00);
        bus_write(16'hD001, 8'h00);
        wait_edges(3);
        check_irq("col_a_pre", 1'b0);
        bus_write(16'hD003, 8'h01);
        check_irq("col_a_irq", 1'b1);
        read_check("col_a_stat", 16'hD003, 8'h01);

        // A load on the expiry edge: the load wins, IF stays 0, and the
        // counter takes the new count 0105.
        bus_write(16'hD002, 8'h07);
        bus_write(16'hD000, 8'h00);
        bus_write(16'hD001, 8'h00);
        bus_write(16'hD000, 8'h05);
        wait_edges(2);
        bus_write(16'hD001, 8'h01);
        check_irq("col_b_irq", 1'b0);
        read_check("col_b_lo", 16'hD000, 8'h05);
        read_check("col_b_hi", 16'hD001, 8'h01);

        // Freeze the timer, then check that activity at D004..D007 has no effect.
        bus_write(16'hD002, 8'h04);
        read_check("idle_stat", 16'hD003, 8'h00);
        @(negedge clk);
        address    = 16'hD004;
        read_write = 1'b1;
        #1;
        check("sel_d004", {15'b0, selected}, 16'h0000);
        check("dout_d004", {8'h00, data_out}, 16'h0000);
        address = 16'hD003;
        #1;
        check("sel_d003", {15'b0, selected}, 16'h0001);
        bus_write(16'hD004, 8'hFF);
        bus_write(16'hD005, 8'hFF);
        bus_write(16'hD006, 8'h03);
        bus_write(16'hD007, 8'h01);
        read_check("unsel_rd",   16'hD004, 8'h00);
        read_check("unsel_lo",   16'hD000, 8'h05);
        read_check("unsel_hi",   16'hD001, 8'h01);
        read_check("unsel_ctrl", 16'hD002, 8'h04);
        read_check("unsel_stat", 16'hD003, 8'h00);

        // CTRL bits 7:3 are not stored.
        bus_write(16'hD002, 8'hFC);
        read_check("ctrl_mask", 16'hD002, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit interval timer that sits directly downstream of the cpu on its bus.
- It decodes the cpu's address, read_write and data_write, and returns read data and an interrupt request.
- Its data_out is OR-combined with the other bus slaves into the cpu's data_read.
- It is the first peripheral slave on the bus and supplies the tick/IRQ source for later interrupt support.

Parameters:
BASE_ADDR, 16'hD000, base of the 4-byte register window; bits [1:0] of the value must be 0.
PRESCALE, 4, clocks per counter tick; must be >= 1.
PRE_W, 8, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
address  input  16  cpu bus address
read_write  input  1  1 = read, 0 = write (6502 convention)
data_write  input  8  cpu write data
data_out  output  8  read data; 8'h00 when not selected
selected  output  1  address within BASE_ADDR..BASE_ADDR+3
irq  output  1  interrupt request, active high

Behaviour:
- Register map (offset = address[1:0] when selected):
  - 0 CNT_L: read returns counter[7:0] and snapshots counter[15:8] into snap_h; write sets latch_l.
  - 1 CNT_H: read returns snap_h; write sets latch_h, performs a load, clears IF.
  - 2 CTRL: R/W. bit0 EN, bit1 CONT (auto-reload), bit2 IE. Bits 7:3 read 0.
  - 3 STAT: read gives {6'b0, running, IF}. Writing 1 to bit0 clears IF; other bits are ignored.
- Read path is combinational: data_out is valid in the same cycle the address is presented, with zero latency, because the cpu samples data_read on the same edge.
- Side effects (snapshot, latch writes, load, IF clear) occur on every clock edge where selected is high with the matching read_write. A multi-cycle hold repeats the side effect, which is harmless.
- irq = IF & IE, combinational from registers.
- Load (CNT_H write):
  - counter <= {data_write, latch_l}; prescaler <= 0.
  - state <= RUN if EN=1, else IDLE.
- Tick: occurs when state==RUN and prescaler==PRESCALE-1. The prescaler wraps to 0 on a tick and otherwise increments only in RUN.
- State machine, states IDLE / RUN / DONE:
  - IDLE: counter and prescaler hold. A CTRL write with EN=1 goes to RUN and resumes from the current count. A load goes to RUN per the EN rule.
  - RUN:
    - Tick with counter!=0: counter decrements.
    - Tick with counter==0: IF <= 1. If CONT=1, counter <= {latch_h, latch_l} and stay in RUN. If CONT=0, counter holds 0 and go to DONE.
    - A CTRL write with EN=0 goes to IDLE and holds counter and prescaler.
  - DONE: counter holds. Only a load leaves DONE; setting EN alone does not restart.
- running = (state==RUN).
- Timing:
  - Value N expires on the (N+1)th tick, i.e. IF rises at edge (N+1)*PRESCALE after the load edge.
  - Continuous period = (N+1)*PRESCALE clocks.
- Simultaneous events:
  - Expiry tick and a STAT clear-write in the same cycle: set wins, IF=1.
  - Expiry tick and a load in the same cycle: the load wins, IF=0, new count.
  - CTRL write and a tick in the same cycle: the tick uses the pre-write CTRL value; the new value applies next cycle.
- Reset (including mid-count): state IDLE; counter, latch_l, latch_h, snap_h, prescaler, CTRL, IF all 0. Hence irq=0, running=0. data_out and selected remain combinational.
- An unselected address causes no state change from bus activity, and data_out=8'h00.

Test Plan:
- Reset state: assert rst mid-RUN -> next cycle running=0, irq=0, reads at D000..D003 all return 00.
- One-shot: write CTRL=05, D000=03, D001=00 -> IF=1 and irq=1 exactly 16 edges after the CNT_H write edge; state DONE, counter 0000, STAT reads 01; no further expiry.
- Continuous: CTRL=07, load 0002 -> IF sets at +12 edges. Clear IF via STAT write 01 -> IF sets again 12 edges after the previous set.
- Coherent read: load 0100, run until the counter passes 00FF. Read D000 (gets FF), wait 8 cycles, read D001 -> returns 00, the snapshot, not the live high byte.
- Pause/resume: during RUN write CTRL=00 -> counter frozen 20 cycles. Write CTRL=01 -> decrement resumes from the frozen value with the prescaler phase preserved.
- Collisions: a STAT clear-write on the expiry edge leaves IF=1. A load on the expiry edge leaves IF=0 with the new count. A write to D004 changes nothing and data_out=00.
